crc_arbiter: RTL and testbench

CRC_ARBITER -- requirements
Module: crc_arbiter

---
 rtl/crc_arbiter.sv | 86 ++++++++
 tb/tb_crc_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_arbiter.sv
// crc_arbiter: round-robin arbiter that hands one requester job at a time to a
// shared CRC engine, ignoring stale engine-ready and aborting on timeout.
module crc_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int MIN_LAT = WIDTH + 1,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] data_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [WIDTH-1:0]      crc_o,
   output logic [NREQ-1:0]       crc_valid_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic                  eng_rd_o,
   output logic [WIDTH-1:0]      eng_data_o,
   input  logic                  eng_ready_i,
   input  logic [WIDTH-1:0]      eng_crc_i
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_LAT);
   localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] last, sel, win, idx;
   logic          err_q;
   // scan descending so the nearest requester after last overrides the rest
   always_comb begin
      win = last;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IW'((int'(last) + 1 + k) % NREQ);
         win = req_i[idx] ? idx : win;
      end
   end
   assign busy_o      = state != IDLE;
   assign eng_rd_o    = state == LOAD;
   assign crc_valid_o = state == RESP ? gnt_o : '0;
   assign err_o       = state == RESP && err_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         gnt_o      <= '0;
         crc_o      <= '0;
         eng_data_o <= '0;
         cnt        <= '0;
         last       <= IW'(NREQ - 1);
         sel        <= '0;
         err_q      <= 1'b0;
      end else
         case (state)
            IDLE:
               if (|req_i) begin
                  sel        <= win;
                  gnt_o      <= '0;
                  gnt_o[win] <= 1'b1;
                  eng_data_o <= data_i[win*WIDTH +: WIDTH];
                  err_q      <= 1'b0;
                  state      <= LOAD;
               end
            LOAD: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT:
               if (cnt >= MIN_C && eng_ready_i) begin
                  crc_o <= eng_crc_i;
                  state <= RESP;
               end else if (cnt == TO_C) begin
                  crc_o <= '0;
                  err_q <= 1'b1;
                  state <= RESP;
               end else
                  cnt <= cnt + 1'b1;
            default: begin
               last  <= sel;
               gnt_o <= '0;
               state <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_crc_arbiter.sv
// tb_crc_arbiter: randomized checks of crc_arbiter against a job-level model of
// round-robin order, engine latency and timeout behaviour.
module tb_crc_arbiter;
   localparam int W = 32, N = 4, ML = W + 1, TO = 64;
   logic clk = 1'b0, rst = 1'b0;
   logic [N-1:0] req = '0;
   logic [W-1:0] dat [N];
   logic [N*W-1:0] data_bus;
   logic [N-1:0] gnt_o, crc_valid_o;
   logic [W-1:0] crc_o, eng_data_o, eng_crc_i;
   logic err_o, busy_o, eng_rd_o, eng_ready_i;
   int tests = 0, fails = 0;
   int eng_d = ML, ecnt = 0, m_last = N - 1;
   logic [W-1:0] ecrc = '0;

   crc_arbiter #(.WIDTH(W), .NREQ(N), .MIN_LAT(ML), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_i(req), .data_i(data_bus), .gnt_o(gnt_o),
      .crc_o(crc_o), .crc_valid_o(crc_valid_o), .err_o(err_o), .busy_o(busy_o),
      .eng_rd_o(eng_rd_o), .eng_data_o(eng_data_o), .eng_ready_i(eng_ready_i),
      .eng_crc_i(eng_crc_i));

   always #5 clk = ~clk;

   always_comb begin
      data_bus = '0;
      for (int i = 0; i < N; i++) data_bus[i*W +: W] = dat[i];
   end

   function automatic logic [W-1:0] crc32(input logic [W-1:0] d);
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int i = 0; i < 32; i++)
         c = {c[30:0], 1'b0} ^ ((c[31] ^ d[31-i]) ? 32'h04C1_1DB7 : 32'h0);
      return ~c;
   endfunction

   // engine: ready rises eng_d cycles after load and then stays high
   always @(posedge clk)
      if (eng_rd_o) begin
         ecnt <= 0;
         ecrc <= crc32(eng_data_o);
      end else if (ecnt < 1_000_000) ecnt <= ecnt + 1;
   assign eng_ready_i = ecnt >= eng_d;
   assign eng_crc_i   = ecrc;

   function automatic int rr(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // cycles from grant to strobe: two fixed cycles plus the qualified wait
   function automatic int exp_lat(input int d);
      return 2 + (d > TO ? TO : (d > ML ? d : ML));
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_last = N - 1;
   endtask

   task automatic run_job(input logic [N-1:0] drop, input int drop_at, output int w,
                          output int gap, output int lat, output int rdn,
                          output logic [N-1:0] gv, output logic [N-1:0] vv,
                          output logic [N-1:0] vnext, output logic [W-1:0] crc,
                          output logic err, output logic [W-1:0] edata, output bit ok);
      ok = 0; gap = 0; w = -1; lat = 0; rdn = 0; gv = '0; vv = '0; vnext = '0;
      crc = '0; err = 1'b0; edata = '0;
      for (int i = 0; i < 20 && gv == 0; i++) begin
         @(negedge clk);
         gap++;
         gv = gnt_o;
      end
      if (gv == 0) return;
      for (int i = 0; i < N; i++) if (gv[i]) w = i;
      edata = eng_data_o;
      rdn = int'(eng_rd_o);
      for (int i = 0; i < 300 && vv == 0; i++) begin
         @(negedge clk);
         lat++;
         if (lat == drop_at) req = req & ~drop;
         rdn += int'(eng_rd_o);
         vv = crc_valid_o;
         crc = crc_o;
         err = err_o;
      end
      if (vv == 0) return;
      req = req & ~vv;
      @(negedge clk);
      vnext = crc_valid_o;
      ok = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '1;
      #1;
      tests++;
      if ({gnt_o, crc_valid_o, err_o, busy_o, eng_rd_o} !== '0) begin
         fails++;
         $display("FAIL reset_ctrl: got gnt=%b valid=%b err=%b busy=%b rd=%b, want all 0",
                  gnt_o, crc_valid_o, err_o, busy_o, eng_rd_o);
      end
      tests++;
      if (crc_o !== '0 || eng_data_o !== '0) begin
         fails++;
         $display("FAIL reset_data: got crc=%h eng_data=%h, want 0", crc_o, eng_data_o);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (busy_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold: busy=%b with req held in reset, want 0", busy_o);
      end
      req = '0;
      rst = 1'b1;
      m_last = N - 1;
   endtask

   task automatic test_single();
      int w, gap, lat, rdn; logic [N-1:0] gv, vv, vn; logic [W-1:0] crc, ed; logic err; bit ok;
      do_reset();
      eng_d = ML;
      dat[0] = 32'h0000_0001;
      req = 4'b0001;
      run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
      tests++;
      if (!ok || gv !== 4'b0001 || vv !== 4'b0001 || rdn != 1 || vn !== '0) begin
         fails++;
         $display("FAIL single_ctrl: ok=%0d gnt=%b valid=%b rd=%0d next=%b, want 1 0001 0001 1 0000",
                  ok, gv, vv, rdn, vn);
      end
      tests++;
      if (crc !== crc32(32'h1) || err !== 1'b0 || ed !== 32'h1) begin
         fails++;
         $display("FAIL single_data: crc=%h err=%b eng_data=%h, want %h 0 00000001",
                  crc, err, ed, crc32(32'h1));
      end
      tests++;
      if (lat != exp_lat(ML)) begin
         fails++;
         $display("FAIL single_lat: got %0d want %0d", lat, exp_lat(ML));
      end
      m_last = 0;
   endtask

   task automatic test_all_req();
      int w, gap, lat, rdn, d; logic [N-1:0] gv, vv, vn; logic [W-1:0] crc, ed; logic err; bit ok;
      do_reset();
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      req = '1;
      for (int j = 0; j < 5; j++) begin
         d = $urandom_range(0, ML + 5);
         eng_d = d;
         run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
         tests++;
         if (!ok || w != j % N || vv !== gv || vn !== '0 || rdn != 1) begin
            fails++;
            $display("FAIL all_order[%0d]: ok=%0d winner=%0d valid=%b next=%b rd=%0d, want winner %0d",
                     j, ok, w, vv, vn, rdn, j % N);
         end
         tests++;
         if (crc !== crc32(dat[j % N]) || err !== 1'b0 || lat != exp_lat(d)) begin
            fails++;
            $display("FAIL all_result[%0d]: crc=%h err=%b lat=%0d, want %h 0 %0d",
                     j, crc, err, lat, crc32(dat[j % N]), exp_lat(d));
         end
         if (j > 0) begin
            tests++;
            if (gap != 1) begin
               fails++;
               $display("FAIL b2b_gap[%0d]: got %0d extra idle cycles, want 1 idle cycle", j, gap);
            end
         end
         dat[w < 0 ? 0 : w] = $urandom;
         req = '1;
         m_last = j % N;
      end
      req = '0;
   endtask

   task automatic test_stale_ready();
      int w, gap, lat, rdn; logic [N-1:0] gv, vv, vn; logic [W-1:0] crc, ed; logic err; bit ok;
      int r = $urandom_range(0, N - 1);
      eng_d = 0;
      dat[r] = $urandom;
      req = '0;
      req[r] = 1'b1;
      run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
      tests++;
      if (!ok || w != r || lat != exp_lat(0) || crc !== crc32(dat[r]) || err !== 1'b0) begin
         fails++;
         $display("FAIL stale_ready: ok=%0d winner=%0d lat=%0d crc=%h err=%b, want %0d %0d %h 0",
                  ok, w, lat, crc, err, r, exp_lat(0), crc32(dat[r]));
      end
      m_last = r;
   endtask

   task automatic test_timeout();
      int w, gap, lat, rdn; logic [N-1:0] gv, vv, vn; logic [W-1:0] crc, ed; logic err; bit ok;
      int r = $urandom_range(0, N - 1);
      int r2 = (r + 1 + $urandom_range(0, N - 2)) % N;
      eng_d = 1_000_000;
      dat[r] = $urandom;
      req = '0;
      req[r] = 1'b1;
      run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
      tests++;
      if (!ok || w != r || lat != 2 + TO || err !== 1'b1 || crc !== '0 || vv !== gv) begin
         fails++;
         $display("FAIL timeout: ok=%0d winner=%0d lat=%0d err=%b crc=%h valid=%b, want %0d %0d 1 0",
                  ok, w, lat, err, crc, vv, r, 2 + TO);
      end
      tests++;
      if (vn !== '0 || err_o !== 1'b0) begin
         fails++;
         $display("FAIL timeout_pulse: next valid=%b err=%b, want 0 0", vn, err_o);
      end
      m_last = r;
      eng_d = ML + 2;
      dat[r2] = $urandom;
      req[r2] = 1'b1;
      run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
      tests++;
      if (!ok || w != r2 || err !== 1'b0 || crc !== crc32(dat[r2]) || lat != exp_lat(ML + 2)) begin
         fails++;
         $display("FAIL after_timeout: ok=%0d winner=%0d err=%b crc=%h lat=%0d, want %0d 0 %h %0d",
                  ok, w, err, crc, lat, r2, crc32(dat[r2]), exp_lat(ML + 2));
      end
      m_last = r2;
   endtask

   task automatic test_random();
      int w, gap, lat, rdn, d, ew, worst; logic [N-1:0] gv, vv, vn, nw; logic [W-1:0] crc, ed; logic err; bit ok;
      int waited [N];
      for (int i = 0; i < N; i++) waited[i] = 0;
      worst = 0;
      req = '0;
      for (int j = 0; j < 20; j++) begin
         nw = N'($urandom) & ~req;
         if ((req | nw) == 0) nw[$urandom_range(0, N - 1)] = 1'b1;
         for (int i = 0; i < N; i++) if (nw[i]) begin dat[i] = $urandom; waited[i] = 0; end
         req = req | nw;
         ew = rr(m_last, req);
         d = $urandom_range(0, TO + 4);
         eng_d = d;
         run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
         tests++;
         if (!ok || w != ew || vv !== gv || rdn != 1 || ed !== dat[ew]) begin
            fails++;
            $display("FAIL rand_grant[%0d]: ok=%0d winner=%0d valid=%b rd=%0d eng_data=%h, want %0d %h",
                     j, ok, w, vv, rdn, ed, ew, dat[ew]);
         end
         tests++;
         if (lat != exp_lat(d) || err !== (d > TO) || crc !== (d > TO ? '0 : crc32(dat[ew]))) begin
            fails++;
            $display("FAIL rand_result[%0d]: lat=%0d err=%b crc=%h, want %0d %b %h", j, lat, err, crc,
                     exp_lat(d), d > TO, d > TO ? '0 : crc32(dat[ew]));
         end
         if (waited[ew] > worst) worst = waited[ew];
         for (int i = 0; i < N; i++) if (req[i]) waited[i]++;
         m_last = ew;
      end
      tests++;
      if (worst >= N) begin
         fails++;
         $display("FAIL fairness: worst wait %0d jobs, want below %0d", worst, N);
      end
      req = '0;
   endtask

   task automatic test_drop_reset();
      int w, gap, lat, rdn; logic [N-1:0] gv, vv, vn; logic [W-1:0] crc, ed; logic err; bit ok;
      do_reset();
      eng_d = ML;
      dat[2] = $urandom;
      req = 4'b0100;
      run_job(4'b0100, 5, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
      tests++;
      if (!ok || vv !== 4'b0100 || crc !== crc32(dat[2]) || err !== 1'b0) begin
         fails++;
         $display("FAIL drop_req: ok=%0d valid=%b crc=%h err=%b, want 0100 %h 0", ok, vv, crc, err, crc32(dat[2]));
      end
      dat[3] = $urandom;
      req = 4'b1000;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = gnt_o != 0; end
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (!ok || {gnt_o, crc_valid_o, err_o, busy_o, eng_rd_o} !== '0 || crc_o !== '0 || eng_data_o !== '0) begin
         fails++;
         $display("FAIL reset_midjob: granted=%0d gnt=%b valid=%b err=%b busy=%b rd=%b crc=%h data=%h, want all 0",
                  ok, gnt_o, crc_valid_o, err_o, busy_o, eng_rd_o, crc_o, eng_data_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      m_last = N - 1;
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      req = '1;
      run_job('0, -1, w, gap, lat, rdn, gv, vv, vn, crc, err, ed, ok);
      tests++;
      if (!ok || w != 0 || vv !== 4'b0001 || crc !== crc32(dat[0])) begin
         fails++;
         $display("FAIL reset_regrant: ok=%0d winner=%0d valid=%b crc=%h, want 0 0001 %h",
                  ok, w, vv, crc, crc32(dat[0]));
      end
      req = '0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) dat[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_reset();
      test_single();
      test_all_req();
      test_stale_ready();
      test_timeout();
      test_random();
      test_drop_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
